// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-facing port.
package vdp_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CRAM_DW = 12;
    localparam int unsigned REG_AW  = 4;

    // Command codes carried in the top two bits of the second control byte
    localparam logic [1:0] CODE_VRAM_RD = 2'd0;
    localparam logic [1:0] CODE_VRAM_WR = 2'd1;
    localparam logic [1:0] CODE_REG_WR  = 2'd2;
    localparam logic [1:0] CODE_CRAM_WR = 2'd3;

    // Bit positions inside the status byte
    localparam int unsigned STAT_VBLANK = 7;
    localparam int unsigned STAT_OVF    = 6;
    localparam int unsigned STAT_COL    = 5;

    localparam logic PORT_DATA = 1'b0;
    localparam logic PORT_CTRL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PF_REQ,
        ST_PF_CAP
    } pf_state_e;

endpackage

// File: rtl/vdp_cpu_port_if.sv
// Z80 bus as seen by the VDP: strobes, port select, data both ways, busy.
interface vdp_cpu_port_if;
    import vdp_pkg::*;

    logic              wr;
    logic              rd;
    logic              port;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              busy;

    modport master (output wr, rd, port, din, input dout, busy);
    modport slave  (input wr, rd, port, din, output dout, busy);
endinterface

// File: rtl/vdp_status.sv
// Status flags, line interrupt pending bit and interrupt request.
module vdp_status
    import vdp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank_set,
    input  logic              line_set,
    input  logic              spr_ovf_set,
    input  logic              spr_col_set,
    input  logic              frame_irq_en,
    input  logic              line_irq_en,
    input  logic              clr_c,
    output logic [DATA_W-1:0] status_c,
    output logic              irq
);

    logic vblank_f, ovf_f, col_f, line_pending;
    logic vblank_nxt, ovf_nxt, col_nxt, line_nxt, irq_nxt;

    // Set pulses beat a same-cycle clear from a status read
    always_comb begin
        vblank_nxt = vblank_set  | (vblank_f     & ~clr_c);
        ovf_nxt    = spr_ovf_set | (ovf_f        & ~clr_c);
        col_nxt    = spr_col_set | (col_f        & ~clr_c);
        line_nxt   = line_set    | (line_pending & ~clr_c);
        irq_nxt    = (vblank_nxt & frame_irq_en) | (line_nxt & line_irq_en);
    end

    // Status byte presented to a control-port read
    always_comb begin
        status_c              = '0;
        status_c[STAT_VBLANK] = vblank_f;
        status_c[STAT_OVF]    = ovf_f;
        status_c[STAT_COL]    = col_f;
    end

    // Flag and irq registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_f     <= 1'b0;
            ovf_f        <= 1'b0;
            col_f        <= 1'b0;
            line_pending <= 1'b0;
            irq          <= 1'b0;
        end else begin
            vblank_f     <= vblank_nxt;
            ovf_f        <= ovf_nxt;
            col_f        <= col_nxt;
            line_pending <= line_nxt;
            irq          <= irq_nxt;
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU port decoder: address counter, read-ahead prefetch, VRAM/CRAM/register writes.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int unsigned VRAM_AW = 14,
    parameter int unsigned CRAM_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    vdp_cpu_port_if.slave      cpu,
    output logic [VRAM_AW-1:0] vram_a,
    output logic [DATA_W-1:0]  vram_dout,
    output logic               vram_we,
    output logic               vram_re,
    input  logic [DATA_W-1:0]  vram_din,
    output logic [CRAM_AW-1:0] cram_a,
    output logic [CRAM_DW-1:0] cram_d,
    output logic               cram_we,
    output logic [REG_AW-1:0]  reg_a,
    output logic [DATA_W-1:0]  reg_d,
    output logic               reg_we,
    input  logic               vblank_set,
    input  logic               line_set,
    input  logic               spr_ovf_set,
    input  logic               spr_col_set,
    input  logic               frame_irq_en,
    input  logic               line_irq_en,
    output logic               irq
);

    pf_state_e          state, state_nxt;
    logic [VRAM_AW-1:0] addr, addr_nxt;
    logic [1:0]         code, code_nxt;
    logic               second, second_nxt;
    logic [DATA_W-1:0]  read_buf, read_buf_nxt;
    logic [DATA_W-1:0]  cram_latch, cram_latch_nxt;
    logic [DATA_W-1:0]  dout_q, dout_nxt;
    logic               busy_q, busy_nxt;
    logic [VRAM_AW-1:0] vram_a_nxt;
    logic [DATA_W-1:0]  vram_dout_nxt;
    logic               vram_we_nxt, vram_re_nxt;
    logic [CRAM_AW-1:0] cram_a_nxt;
    logic [CRAM_DW-1:0] cram_d_nxt;
    logic               cram_we_nxt;
    logic [REG_AW-1:0]  reg_a_nxt;
    logic [DATA_W-1:0]  reg_d_nxt;
    logic               reg_we_nxt;
    logic               start_pf_c;
    logic               stat_clr_c;
    logic [DATA_W-1:0]  status_c;

    assign cpu.dout = dout_q;
    assign cpu.busy = busy_q;

    // Decode strobes (only when idle; write beats read) and sequence the prefetch
    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        code_nxt       = code;
        second_nxt     = second;
        read_buf_nxt   = read_buf;
        cram_latch_nxt = cram_latch;
        dout_nxt       = dout_q;
        busy_nxt       = busy_q;
        vram_a_nxt     = vram_a;
        vram_dout_nxt  = vram_dout;
        vram_we_nxt    = 1'b0;
        vram_re_nxt    = 1'b0;
        cram_a_nxt     = cram_a;
        cram_d_nxt     = cram_d;
        cram_we_nxt    = 1'b0;
        reg_a_nxt      = reg_a;
        reg_d_nxt      = reg_d;
        reg_we_nxt     = 1'b0;
        start_pf_c     = 1'b0;
        stat_clr_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (cpu.wr && cpu.port == PORT_CTRL) begin
                    if (!second) begin
                        addr_nxt[7:0] = cpu.din;
                        second_nxt    = 1'b1;
                    end else begin
                        code_nxt                = cpu.din[7:6];
                        addr_nxt[VRAM_AW-1:8]   = cpu.din[VRAM_AW-9:0];
                        second_nxt              = 1'b0;
                        if (cpu.din[7:6] == CODE_VRAM_RD) begin
                            start_pf_c = 1'b1;
                        end else if (cpu.din[7:6] == CODE_REG_WR) begin
                            reg_a_nxt  = cpu.din[REG_AW-1:0];
                            reg_d_nxt  = addr[7:0];
                            reg_we_nxt = 1'b1;
                        end
                    end
                end else if (cpu.wr) begin
                    second_nxt   = 1'b0;
                    read_buf_nxt = cpu.din;
                    addr_nxt     = addr + VRAM_AW'(1);
                    if (code != CODE_CRAM_WR) begin
                        vram_a_nxt    = addr;
                        vram_dout_nxt = cpu.din;
                        vram_we_nxt   = 1'b1;
                    end else if (!addr[0]) begin
                        cram_latch_nxt = cpu.din;
                    end else begin
                        cram_a_nxt  = addr[CRAM_AW:1];
                        cram_d_nxt  = {cpu.din[3:0], cram_latch};
                        cram_we_nxt = 1'b1;
                    end
                end else if (cpu.rd && cpu.port == PORT_DATA) begin
                    dout_nxt   = read_buf;
                    second_nxt = 1'b0;
                    start_pf_c = 1'b1;
                end else if (cpu.rd) begin
                    dout_nxt   = status_c;
                    second_nxt = 1'b0;
                    stat_clr_c = 1'b1;
                end
            end
            ST_PF_REQ: begin
                busy_nxt  = 1'b1;
                state_nxt = ST_PF_CAP;
            end
            ST_PF_CAP: begin
                read_buf_nxt = vram_din;
                addr_nxt     = addr + VRAM_AW'(1);
                busy_nxt     = 1'b0;
                state_nxt    = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        if (start_pf_c) begin
            state_nxt   = ST_PF_REQ;
            vram_re_nxt = 1'b1;
            vram_a_nxt  = addr_nxt;
            busy_nxt    = 1'b1;
        end
    end

    // State and registered outputs; reset aborts any prefetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr       <= '0;
            code       <= '0;
            second     <= 1'b0;
            read_buf   <= '0;
            cram_latch <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            vram_a     <= '0;
            vram_dout  <= '0;
            vram_we    <= 1'b0;
            vram_re    <= 1'b0;
            cram_a     <= '0;
            cram_d     <= '0;
            cram_we    <= 1'b0;
            reg_a      <= '0;
            reg_d      <= '0;
            reg_we     <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            code       <= code_nxt;
            second     <= second_nxt;
            read_buf   <= read_buf_nxt;
            cram_latch <= cram_latch_nxt;
            dout_q     <= dout_nxt;
            busy_q     <= busy_nxt;
            vram_a     <= vram_a_nxt;
            vram_dout  <= vram_dout_nxt;
            vram_we    <= vram_we_nxt;
            vram_re    <= vram_re_nxt;
            cram_a     <= cram_a_nxt;
            cram_d     <= cram_d_nxt;
            cram_we    <= cram_we_nxt;
            reg_a      <= reg_a_nxt;
            reg_d      <= reg_d_nxt;
            reg_we     <= reg_we_nxt;
        end
    end

    vdp_status u_status (
        .clk          (clk),
        .rst          (rst),
        .vblank_set   (vblank_set),
        .line_set     (line_set),
        .spr_ovf_set  (spr_ovf_set),
        .spr_col_set  (spr_col_set),
        .frame_irq_en (frame_irq_en),
        .line_irq_en  (line_irq_en),
        .clr_c        (stat_clr_c),
        .status_c     (status_c),
        .irq          (irq)
    );

endmodule
